// File: rtl/axi4_wr_burst_splitter.sv
// Splits an upstream AXI4 INCR write burst into single-beat downstream AW/W/B transactions.
// Optional build macro AXI_WSPLIT_4K_CHECK_EN: drain and reject bursts that cross a 4 KiB page.
module axi4_wr_burst_splitter #(
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_RESP  = 3'd3,
`ifdef AXI_WSPLIT_4K_CHECK_EN
    S_DRAIN = 3'd5,
`endif
    S_BRSP  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [1:0]              acc_q, acc_d;
  logic                    awready_q, awready_d;
  logic [ADDR_WIDTH-1:0]   beat_addr;

  assign beat_addr = addr_q + ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(STRB_W);
  assign s_awready = awready_q;

`ifdef AXI_WSPLIT_4K_CHECK_EN
  // Page of the last beat versus page of the first beat, with address-space wrap.
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  page_cross;
  assign last_addr  = s_awaddr + ADDR_WIDTH'(s_awlen) * ADDR_WIDTH'(STRB_W);
  assign page_cross = (last_addr[ADDR_WIDTH-1:12] != s_awaddr[ADDR_WIDTH-1:12]);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      awready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      awready_q <= awready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = 2'b00;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_awvalid && awready_q) begin
          id_d    = s_awid;
          addr_d  = s_awaddr;
          len_d   = s_awlen;
          cnt_d   = '0;
          acc_d   = 2'b00;
          state_d = S_ADDR;
`ifdef AXI_WSPLIT_4K_CHECK_EN
          if (page_cross) begin
            acc_d   = 2'b10;
            state_d = S_DRAIN;
          end
`endif
        end
      end
      S_ADDR: begin
        m_awvalid = 1'b1;
        m_awaddr  = beat_addr;
        if (m_awready) state_d = S_DATA;
      end
      // W channel is a straight combinational connection for the current beat.
      S_DATA: begin
        m_wvalid = s_wvalid;
        s_wready = m_wready;
        m_wdata  = s_wdata;
        m_wstrb  = s_wstrb;
        if (s_wvalid && m_wready) state_d = S_RESP;
      end
      S_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (m_bresp > acc_q) acc_d = m_bresp;
          if (cnt_q == len_q) begin
            state_d = S_BRSP;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_BRSP: begin
        s_bvalid = 1'b1;
        s_bid    = id_q;
        s_bresp  = acc_q;
        if (s_bready) state_d = S_IDLE;
      end
`ifdef AXI_WSPLIT_4K_CHECK_EN
      S_DRAIN: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          if (cnt_q == len_q) state_d = S_BRSP;
          else                cnt_d   = cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    awready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_axi4_wr_burst_splitter.sv
// Self-checking bench for axi4_wr_burst_splitter: directed and randomized bursts against a burst-level model.
module tb_axi4_wr_burst_splitter;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 12;
  localparam int unsigned SW = DW / 8;

  logic          clock;
  logic          reset;
  logic          s_awvalid, s_awready;
  logic [IW-1:0] s_awid;
  logic [AW-1:0] s_awaddr;
  logic [7:0]    s_awlen;
  logic          s_wvalid, s_wready;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_bvalid, s_bready;
  logic [IW-1:0] s_bid;
  logic [1:0]    s_bresp;
  logic          m_awvalid, m_awready;
  logic [AW-1:0] m_awaddr;
  logic          m_wvalid, m_wready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_bvalid, m_bready;
  logic [1:0]    m_bresp;

  axi4_wr_burst_splitter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [1:0] resp_a [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected byte address of beat i: start + i*beat bytes, modulo the address space.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int i);
    longint full;
    full = (longint'(a) + longint'(i) * longint'(SW)) % (longint'(1) << AW);
    return AW'(full);
  endfunction

  function automatic bit crosses(input logic [AW-1:0] a, input int len);
    return (beat_addr(a, len) / 4096) != (a / 4096);
  endfunction

  task automatic outputs_zero(input string tag);
    check({tag, "_ctl"}, 128'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}), 128'(0));
    check({tag, "_dat"}, 128'({s_bid, s_bresp, m_awaddr, m_wdata, m_wstrb}), 128'(0));
  endtask

  task automatic burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                       input bit stall, input int wst_beat, input int wst_cyc, input int abort_at);
    logic [1:0]    exp_resp;
    bit            drain;
    int            t;
    logic [DW-1:0] d;
    logic [SW-1:0] st;
    drain = 1'b0;
`ifdef AXI_WSPLIT_4K_CHECK_EN
    drain = crosses(addr, len);
`endif
    exp_resp = 2'b00;
    for (int i = 0; i <= len; i++) if (resp_a[i] > exp_resp) exp_resp = resp_a[i];
    if (drain) exp_resp = 2'b10;

    @(negedge clock);
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = 8'(len);
    t = 0; #1;
    while (!s_awready && t < 50) begin @(negedge clock); #1; t++; end
    if (!s_awready) begin check("aw_timeout", 128'(0), 128'(1)); s_awvalid = 1'b0; return; end
    @(negedge clock);
    s_awvalid = 1'b0; s_awid = IW'($urandom); s_awaddr = AW'($urandom); s_awlen = 8'($urandom);

    if (drain) begin
      for (int i = 0; i <= len; i++) begin
        s_wvalid = 1'b1; s_wdata = $urandom;
        #1;
        check("drain_wready", 128'(s_wready), 128'(1));
        check("drain_quiet", 128'({m_awvalid, m_wvalid, m_bready}), 128'(0));
        @(negedge clock);
      end
      s_wvalid = 1'b0;
    end else begin
      for (int i = 0; i <= len; i++) begin
        t = 0; #1;
        while (!m_awvalid && t < 50) begin @(negedge clock); #1; t++; end
        if (!m_awvalid) begin check("m_aw_timeout", 128'(0), 128'(1)); return; end
        check($sformatf("awaddr[%0d]", i), 128'(m_awaddr), 128'(beat_addr(addr, i)));
        if (stall) repeat ($urandom_range(0, 3)) begin
          @(negedge clock); #1;
          check("aw_hold", 128'({m_awvalid, m_awaddr}), 128'({1'b1, beat_addr(addr, i)}));
        end
        m_awready = 1'b1;
        @(negedge clock);
        m_awready = 1'b0;

        d = $urandom; st = SW'($urandom);
        s_wvalid = 1'b1; s_wdata = d; s_wstrb = st;
        if (i == wst_beat) for (int c = 0; c < wst_cyc; c++) begin
          #1;
          check("wstall", 128'({s_wready, m_wvalid, m_wdata}), 128'({1'b0, 1'b1, d}));
          @(negedge clock);
        end
        m_wready = 1'b1; #1;
        check($sformatf("wbeat[%0d]", i), 128'({s_wready, m_wvalid, m_wdata, m_wstrb}),
              128'({1'b1, 1'b1, d, st}));
        @(negedge clock);
        s_wvalid = 1'b0; m_wready = 1'b0;

        if (stall) repeat ($urandom_range(0, 3)) begin
          #1; check("b_wait", 128'({m_bready, m_awvalid}), 128'({1'b1, 1'b0})); @(negedge clock);
        end
        if (i == abort_at) begin
          reset = 1'b1; #1;
          outputs_zero("abort");
          repeat (3) begin @(negedge clock); #1; outputs_zero("in_reset"); end
          @(negedge clock);
          reset = 1'b0;
          return;
        end
        m_bvalid = 1'b1; m_bresp = resp_a[i]; #1;
        check("bready", 128'(m_bready), 128'(1));
        @(negedge clock);
        m_bvalid = 1'b0; m_bresp = 2'b00;
      end
    end

    t = 0; #1;
    while (!s_bvalid && t < 50) begin @(negedge clock); #1; t++; end
    check("bvalid", 128'(s_bvalid), 128'(1));
    check("bid_bresp", 128'({s_bid, s_bresp}), 128'({id, exp_resp}));
    check("no_extra_aw", 128'({m_awvalid, m_wvalid}), 128'(0));
    if (stall) repeat (2) begin
      @(negedge clock); #1;
      check("b_hold", 128'({s_bvalid, s_bid, s_bresp}), 128'({1'b1, id, exp_resp}));
    end
    @(negedge clock);
    s_bready = 1'b1;
    @(negedge clock);
    s_bready = 1'b0; #1;
    check("b_done", 128'(s_bvalid), 128'(0));
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0;
    s_wvalid = 0; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_bready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    foreach (resp_a[i]) resp_a[i] = 2'b00;

    // Reset state and release behaviour of s_awready.
    repeat (3) @(negedge clock);
    #1; outputs_zero("reset");
    @(negedge clock);
    reset = 1'b0; #1;
    check("awready_at_release", 128'(s_awready), 128'(0));
    @(posedge clock); #1;
    check("awready_after_release", 128'(s_awready), 128'(1));

    // Four-beat burst, no stalls, all OKAY.
    burst(12'hA5C, 25'h100, 3, 1'b0, -1, 0, -1);

    // Single beat with SLVERR.
    resp_a[0] = 2'b10;
    burst(12'h011, 25'h2000, 0, 1'b0, -1, 0, -1);

    // Merged EXOKAY with a 10-cycle W stall on beat 1.
    resp_a[0] = 2'b00; resp_a[1] = 2'b01; resp_a[2] = 2'b00;
    burst(12'h3C3, 25'h340, 2, 1'b0, 1, 10, -1);

    // Address-space wrap at the top.
    resp_a[0] = 2'b00; resp_a[1] = 2'b00;
    burst(12'h7FF, 25'h1FFFFFC, 1, 1'b1, -1, 0, -1);

    // Reset in RESP of beat 2 of an 8-beat burst, then a clean burst.
    burst(12'h0AB, 25'h4000, 7, 1'b0, -1, 0, 2);
    #1; check("post_abort_quiet", 128'({s_bvalid, m_awvalid}), 128'(0));
    burst(12'h0CD, 25'h4100, 1, 1'b0, -1, 0, -1);

    // Page-crossing burst: drained with SLVERR when the check is built in, split otherwise.
    burst(12'h123, 25'hFFC, 1, 1'b0, -1, 0, -1);

    // Randomized bursts with random stalls and responses.
    for (int k = 0; k < 10; k++) begin
      int len;
      len = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) resp_a[i] = 2'($urandom_range(0, 3));
      burst(IW'($urandom), AW'($urandom), len, 1'b1, $urandom_range(0, 15), $urandom_range(1, 4), -1);
    end

    // Maximum length burst within one page.
    for (int i = 0; i < 256; i++) resp_a[i] = (i == 200) ? 2'b11 : 2'($urandom_range(0, 1));
    burst(12'hFFF, 25'h20000, 255, 1'b0, 128, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_wr_burst_splitter.md
AXI4_WR_BURST_SPLITTER -- requirements
Module: axi4_wr_burst_splitter

Interface
REQ-001 The block SHALL have parameters ADDR_WIDTH = 25 (byte-address width), DATA_WIDTH = 32 (beat width) and ID_WIDTH = 12 (transaction ID width).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed:
 clock  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high
 s_awvalid  in  1  upstream AW valid
 s_awready  out  1  upstream AW ready
 s_awid  in  ID_WIDTH  burst ID
 s_awaddr  in  ADDR_WIDTH  burst start byte address
 s_awlen  in  8  beats minus 1 (INCR, full-width beats)
 s_wvalid  in  1  upstream W valid
 s_wready  out  1  upstream W ready
 s_wdata  in  DATA_WIDTH  write data
 s_wstrb  in  DATA_WIDTH/8  byte strobes
 s_bvalid  out  1  upstream B valid
 s_bready  in  1  upstream B ready
 s_bid  out  ID_WIDTH  response ID
 s_bresp  out  2  merged response
 m_awvalid  out  1  downstream single-beat AW valid
 m_awready  in  1  downstream AW ready
 m_awaddr  out  ADDR_WIDTH  beat address
 m_wvalid  out  1  downstream W valid
 m_wready  in  1  downstream W ready
 m_wdata  out  DATA_WIDTH  beat data
 m_wstrb  out  DATA_WIDTH/8  beat strobes
 m_bvalid  in  1  downstream B valid
 m_bready  out  1  downstream B ready
 m_bresp  in  2  beat response

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, DATA, RESP, BRSP and DRAIN, and SHALL keep exactly one downstream transaction outstanding at any time.
REQ-004 In IDLE the block SHALL drive s_awready=1; on an AW handshake it SHALL capture id, addr and len, clear beat counter cnt and merged response acc, and go to ADDR.
REQ-005 In ADDR the block SHALL drive m_awvalid=1 with m_awaddr = captured addr + cnt*(DATA_WIDTH/8), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH); on m_awready it SHALL go to DATA.
REQ-006 In DATA the block SHALL connect the W channel combinationally: m_wvalid = s_wvalid, s_wready = m_wready, and data/strb pass through; on a handshake it SHALL go to RESP. s_wlast SHALL be ignored.
REQ-007 In RESP the block SHALL drive m_bready=1; on m_bvalid it SHALL set acc = max(acc, m_bresp). If cnt == len it SHALL go to BRSP; otherwise it SHALL increment cnt and go to ADDR.
REQ-008 In BRSP the block SHALL drive s_bvalid=1, s_bid = captured id and s_bresp = acc, holding them stable until s_bready; on s_bready it SHALL go to IDLE.
REQ-009 Outside their owning states, s_awready, s_wready, m_awvalid, m_wvalid, m_bready and s_bvalid SHALL be 0.
REQ-010 A burst of len+1 beats SHALL produce exactly len+1 downstream AW/W/B triples; len=255 SHALL be supported with an 8-bit counter and no overflow.
REQ-011 Downstream stalls (m_awready, m_wready or m_bvalid held low) SHALL hold the state indefinitely with no loss of captured data.

Reset
REQ-012 While reset is asserted, the state SHALL be IDLE, cnt, acc and all captured registers SHALL be 0, and every output SHALL be 0 except s_awready, which SHALL rise only after reset deasserts.
REQ-013 Reset asserted mid-burst SHALL abandon the burst immediately, with no further downstream beats and no upstream B response.

Configuration
REQ-014 When AXI_WSPLIT_4K_CHECK_EN is defined, a burst whose last beat lies in a different 4 KiB page than its start SHALL go IDLE->DRAIN. DRAIN SHALL issue no downstream traffic, drive s_wready=1, consume len+1 W beats, then go to BRSP with s_bresp=2'b10 (SLVERR).
REQ-015 When AXI_WSPLIT_4K_CHECK_EN is undefined, DRAIN SHALL be absent and every burst SHALL be split per REQ-005, regardless of page crossing.

Verification
REQ-016 AW addr=0x100, len=3, downstream always ready, all bresp=0 -> m_awaddr 0x100/0x104/0x108/0x10C in order, one s_bvalid with bresp=0 and bid equal to the AW ID.
REQ-017 len=0, m_bresp=2'b10 -> one downstream beat, s_bresp=2'b10.
REQ-018 len=2, beat bresps 0, 1, 0 -> s_bresp=2'b01; m_wready held low 10 cycles on beat 1 -> s_wready low for the same cycles, data intact.
REQ-019 addr=0x1FFFFFC (top of address space), len=1 -> second m_awaddr=0x0000000 (wrap).
REQ-020 Reset asserted in RESP of beat 2 of len=7 -> all outputs 0 next cycle, no s_bvalid; after release, a new burst completes normally.
REQ-021 With AXI_WSPLIT_4K_CHECK_EN defined: addr=0xFFC, len=1 -> no m_awvalid, 2 W beats accepted, s_bresp=2'b10.
